// File: rtl/sp_ram_param.sv
// Parametrised single-port synchronous RAM with per-byte enables,
// selectable read-during-write mode, optional output stage and zero-fill init.
module sp_ram_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   q,
  output logic                    q_valid,
  output logic                    err,
  output logic                    ready
);

  localparam int BW = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  in_range;
  logic                  pulse;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] result;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BW-1:0]         wr_be;

  logic [DATA_WIDTH-1:0] s1_q;
  logic                  s1_v;
  logic                  s1_e;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign ready    = (state_q == RUN);
  assign accept   = ready & req;
  assign in_range = ({1'b0, addr} < LIMIT);
  assign old_word = mem[addr];

  always_comb begin
    merged = old_word;
    for (int i = 0; i < BW; i++) begin
      if (be[i]) merged[8*i +: 8] = data[8*i +: 8];
    end
  end

  // no-change mode suppresses the pulse on any write accept
  assign pulse = accept & ~(we & (RDW_MODE == 2));

  always_comb begin
    result = old_word;
    if (!in_range) begin
      result = '0;
    end else if (we && (RDW_MODE == 1)) begin
      result = merged;
    end
  end

  always_comb begin
    wr_en   = accept & we & in_range;
    wr_addr = addr;
    wr_data = data;
    wr_be   = be;
    if (state_q == INIT) begin
      wr_en   = 1'b1;
      wr_addr = cnt_q;
      wr_data = '0;
      wr_be   = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BW; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s1_v <= 1'b0;
      s1_e <= 1'b0;
    end else begin
      s1_v <= pulse;
      s1_e <= pulse & ~in_range;
      if (pulse) s1_q <= result;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q       <= '0;
          q_valid <= 1'b0;
          err     <= 1'b0;
        end else begin
          q_valid <= s1_v;
          err     <= s1_e;
          if (s1_v) q <= s1_q;
        end
      end
    end else begin : g_noreg
      assign q       = s1_q;
      assign q_valid = s1_v;
      assign err     = s1_e;
    end
  endgenerate

endmodule

// File: tb/tb_sp_ram_param.sv
// Directed bench for sp_ram_param: five instances cover width, RDW modes,
// output register, partial depth and reset behaviour.
module tb_sp_ram_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [5:0]  addr = '0;
  logic [31:0] data = '0;
  logic [3:0]  be = '0;

  logic [31:0] qa;
  logic [7:0]  qb, qc, qd, qe;
  logic        qv_a, qv_b, qv_c, qv_d, qv_e;
  logic        err_a, err_b, err_c, err_d, err_e;
  logic        rdy_a, rdy_b, rdy_c, rdy_d, rdy_e;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // A: 32-bit, read-first, latency 1
  sp_ram_param #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .DEPTH(64),
                 .RDW_MODE(0), .OUT_REG(0)) u_a (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
    .data(data), .be(be), .q(qa), .q_valid(qv_a),
    .err(err_a), .ready(rdy_a));

  sp_ram_param #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .DEPTH(64),
                 .RDW_MODE(1), .OUT_REG(0)) u_b (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
    .data(data[7:0]), .be(be[0:0]), .q(qb), .q_valid(qv_b),
    .err(err_b), .ready(rdy_b));

  sp_ram_param #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .DEPTH(64),
                 .RDW_MODE(2), .OUT_REG(0)) u_c (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
    .data(data[7:0]), .be(be[0:0]), .q(qc), .q_valid(qv_c),
    .err(err_c), .ready(rdy_c));

  sp_ram_param #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .DEPTH(64),
                 .RDW_MODE(0), .OUT_REG(1)) u_d (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
    .data(data[7:0]), .be(be[0:0]), .q(qd), .q_valid(qv_d),
    .err(err_d), .ready(rdy_d));

  sp_ram_param #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .DEPTH(48),
                 .RDW_MODE(0), .OUT_REG(0)) u_e (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
    .data(data[7:0]), .be(be[0:0]), .q(qe), .q_valid(qv_e),
    .err(err_e), .ready(rdy_e));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic r, input logic w,
                    input logic [5:0] a, input logic [31:0] d,
                    input logic [3:0] b);
    @(negedge clk);
    req = r; we = w; addr = a; data = d; be = b;
    @(posedge clk);
    #1;
  endtask

  // counts edges after rst release until ready; no pulses allowed before
  task automatic init_wait(input string tag);
    int ra = 0;
    int rd = 0;
    int re = 0;
    int early = 0;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk);
      #1;
      if (rdy_a && ra == 0) ra = i;
      if (rdy_d && rd == 0) rd = i;
      if (rdy_e && re == 0) re = i;
      if (!rdy_a && (qv_a || err_a)) early++;
      if (!rdy_d && (qv_d || err_d)) early++;
      if (!rdy_e && (qv_e || err_e)) early++;
    end
    chk({tag, " ready_a cycle"}, ra, 64);
    chk({tag, " ready_d cycle"}, rd, 64);
    chk({tag, " ready_e cycle"}, re, 48);
    chk({tag, " pulses in init"}, early, 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    req = 1'b1; we = 1'b0; addr = 6'd5; be = 4'hF;
    @(posedge clk);
    #1;
    chk("rst q", qa, 0);
    chk("rst q_valid", qv_a, 0);
    chk("rst err", err_a, 0);
    chk("rst ready", rdy_a, 0);

    // init sweep with req held high
    @(negedge clk) rst = 1'b0;
    init_wait("init1");
    op(1, 0, 6'd5, 0, 4'hF);
    chk("init read5 qv", qv_a, 1);
    chk("init read5 q", qa, 0);
    op(0, 0, 0, 0, 0);
    chk("idle qv", qv_a, 0);

    // byte enables
    op(1, 1, 6'd3, 32'hAABBCCDD, 4'hF);
    chk("be wr1 q", qa, 0);
    chk("be wr1 qv", qv_a, 1);
    op(1, 1, 6'd3, 32'h11223344, 4'h5);
    chk("be wr2 q", qa, 32'hAABBCCDD);
    op(1, 0, 6'd3, 0, 4'h0);
    chk("be read q", qa, 32'hAA22CC44);
    chk("be read qv", qv_a, 1);
    chk("be read b", qb, 8'h44);
    op(0, 0, 0, 0, 0);
    chk("be hold q", qa, 32'hAA22CC44);
    chk("be hold qv", qv_a, 0);

    // read-during-write modes
    op(1, 1, 6'd7, 32'h12, 4'hF);
    op(1, 1, 6'd7, 32'h34, 4'hF);
    chk("rdw0 q", qa, 32'h12);
    chk("rdw0 qv", qv_a, 1);
    chk("rdw1 q", qb, 8'h34);
    chk("rdw1 qv", qv_b, 1);
    chk("rdw2 q", qc, 8'h44);
    chk("rdw2 qv", qv_c, 0);
    op(1, 0, 6'd7, 0, 4'hF);
    chk("rdw0 rd", qa, 32'h34);
    chk("rdw1 rd", qb, 8'h34);
    chk("rdw2 rd", qc, 8'h34);
    chk("rdw2 rd qv", qv_c, 1);

    // latency 2 streaming
    op(1, 1, 6'd0, 32'hA0, 4'hF);
    op(1, 1, 6'd1, 32'hA1, 4'hF);
    op(1, 1, 6'd2, 32'hA2, 4'hF);
    op(0, 0, 0, 0, 0);
    op(0, 0, 0, 0, 0);
    op(1, 0, 6'd0, 0, 4'hF);
    chk("lat2 c0 qv", qv_d, 0);
    op(1, 0, 6'd1, 0, 4'hF);
    chk("lat2 c1 qv", qv_d, 1);
    chk("lat2 c1 q", qd, 8'hA0);
    op(1, 0, 6'd2, 0, 4'hF);
    chk("lat2 c2 qv", qv_d, 1);
    chk("lat2 c2 q", qd, 8'hA1);
    op(0, 0, 0, 0, 0);
    chk("lat2 c3 qv", qv_d, 1);
    chk("lat2 c3 q", qd, 8'hA2);
    op(0, 0, 0, 0, 0);
    chk("lat2 c4 qv", qv_d, 0);
    chk("lat2 c4 q", qd, 8'hA2);

    // out of range on the 48-word instance
    op(1, 1, 6'd50, 32'hFF, 4'hF);
    chk("oor wr qv", qv_e, 1);
    chk("oor wr err", err_e, 1);
    chk("oor wr q", qe, 0);
    op(1, 0, 6'd50, 0, 4'hF);
    chk("oor rd qv", qv_e, 1);
    chk("oor rd err", err_e, 1);
    chk("oor rd q", qe, 0);
    chk("full depth err", err_a, 0);
    chk("full depth q", qa, 32'hFF);
    op(1, 0, 6'd47, 0, 4'hF);
    chk("edge rd err", err_e, 0);
    chk("edge rd qv", qv_e, 1);
    chk("edge rd q", qe, 0);
    op(1, 0, 6'd2, 0, 4'hF);
    chk("oor no alias", qe, 8'hA2);
    chk("oor pulse len", err_e, 0);
    op(0, 0, 0, 0, 0);

    // reset with a latency-2 read in flight
    op(1, 0, 6'd1, 0, 4'hF);
    rst = 1'b1;
    req = 1'b0;
    #1;
    chk("rst fl q_d", qd, 0);
    chk("rst fl qv_d", qv_d, 0);
    chk("rst fl ready_d", rdy_d, 0);
    chk("rst fl q_a", qa, 0);
    chk("rst fl ready_a", rdy_a, 0);
    @(negedge clk) rst = 1'b0;
    init_wait("init2");
    chk("init2 q_d", qd, 0);

    // reset at cnt=20 must restart the full sweep
    op(1, 1, 6'd60, 32'h5A5A5A5A, 4'hF);
    op(0, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid init ready", rdy_a, 0);
    chk("mid init qv", qv_a, 0);
    @(negedge clk) rst = 1'b0;
    init_wait("init3");
    op(1, 0, 6'd60, 0, 4'hF);
    chk("reinit rd60 q", qa, 0);
    chk("reinit rd60 qv", qv_a, 1);
    op(1, 0, 6'd7, 0, 4'hF);
    chk("reinit rd7 q", qa, 0);
    op(0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sp_ram_param.md
Name: sp_ram_param

Overview:
Parametrised single-port synchronous RAM, the next generation of the team's fixed 8x64 single-port RAM. Adds configurable width and depth, per-byte write enables, selectable read-during-write mode, an optional output register stage, a request/valid handshake, and a hardware zero-fill sequencer after reset. Used as the generic local storage macro in datapath blocks.

Parameters:
DATA_WIDTH, 8, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 6, address width.
DEPTH, 64, number of words; 1 <= DEPTH <= 2**ADDR_WIDTH.
RDW_MODE, 0, read-during-write: 0 = read-first (old data), 1 = write-first (new data), 2 = no-change (q holds, no q_valid).
OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
req  input  1  access request; sampled only when ready=1.
we  input  1  1 = write, 0 = read; qualified by req.
addr  input  ADDR_WIDTH  word address.
data  input  DATA_WIDTH  write data.
be  input  DATA_WIDTH/8  byte enables; be[i] writes data[8i+7:8i].
q  output  DATA_WIDTH  read data.
q_valid  output  1  one-cycle pulse; q carries the result of an accepted access.
err  output  1  one-cycle pulse aligned with q_valid; the access was out of range.
ready  output  1  1 = init complete, accepting requests.

Behaviour:
- Reset (async, rst=1): q=0, q_valid=0, err=0, ready=0. The FSM enters INIT with the sweep counter at 0. Array contents are not reset directly.
- FSM states: INIT and RUN.
  - INIT writes 0 to word [cnt] each cycle for cnt = 0..DEPTH-1.
  - After writing word DEPTH-1, the FSM moves to RUN. ready=1 from the next cycle, i.e. exactly DEPTH cycles after rst deasserts.
  - req is ignored in INIT: no write, no q_valid.
  - rst asserted in any state, including mid-INIT, restarts INIT from 0.
- Accept condition: at a clock edge with ready=1 and req=1. One access per cycle; back-to-back accepts are allowed every cycle with no bubbles.
- Write (we=1, addr<DEPTH): only bytes with be[i]=1 are updated. be=0 is a legal no-op write, with the handshake still following RDW_MODE.
- Read-during-write, on a write accept:
  - RDW_MODE=0: q = pre-write word, q_valid pulses.
  - RDW_MODE=1: q = post-write word (merged per be), q_valid pulses.
  - RDW_MODE=2: q holds its value, no q_valid.
- Read (we=0, addr<DEPTH): returns the stored word.
- Out of range (addr>=DEPTH):
  - The array is unchanged.
  - Where q_valid would pulse, q=0 and err pulses with it.
  - In RDW_MODE=2, an out-of-range write produces no pulse.
- Latency:
  - OUT_REG=0: an accept at edge N gives q/q_valid/err valid after edge N, i.e. during cycle N+1.
  - OUT_REG=1: valid after edge N+1.
  - The pipeline is fully pipelined, one result per cycle.
- q holds its last value whenever q_valid=0. q_valid and err are never asserted in INIT or during reset.
- Reset mid-pipeline: in-flight results are discarded, and the outputs take their reset values immediately.
- Width rules: be width = DATA_WIDTH/8. The addr>=DEPTH comparison uses the full ADDR_WIDTH value. When DEPTH = 2**ADDR_WIDTH, err never fires.

Test Plan:
1. Init sweep:
   - Stimulus: DEPTH=64, release rst, hold req=1 throughout.
   - Required: ready rises exactly 64 cycles after rst falls; no q_valid before that; a read of addr 5 then returns q=0x00.
2. Byte enables:
   - Stimulus: DATA_WIDTH=32. Write 0xAABBCCDD with be=4'b1111 to addr 3, then 0x11223344 with be=4'b0101 to addr 3, then read addr 3.
   - Required: q=0xAA22CC44, q_valid one cycle after the read accept (OUT_REG=0).
3. RDW modes:
   - Stimulus: addr 7 holds 0x12; write 0x34 to addr 7, once per mode.
   - Required: mode 0 gives q=0x12 with q_valid; mode 1 gives q=0x34 with q_valid; mode 2 gives no q_valid and q unchanged. A following read of addr 7 returns 0x34 in all three modes.
4. Latency and streaming:
   - Stimulus: OUT_REG=1, reads of addr 0,1,2 on consecutive cycles, preloaded with 0xA0, 0xA1, 0xA2.
   - Required: q_valid is high for 3 consecutive cycles starting 2 cycles after the first accept, with q = 0xA0, 0xA1, 0xA2.
5. Out of range:
   - Stimulus: DEPTH=48, ADDR_WIDTH=6. Write 0xFF to addr 50, then read addr 50, then read addr 47.
   - Required: the write does not alter any word. The addr 50 read gives q=0 with err=1 and q_valid=1. The addr 47 read gives err=0.
6. Reset mid-operation:
   - Stimulus: assert rst during INIT at cnt=20, and separately with a read in flight (OUT_REG=1).
   - Required: q, q_valid, err and ready go to 0 immediately. The in-flight result never appears. INIT restarts, and ready rises DEPTH cycles after rst falls.
